// File: rtl/sram_mode_sequencer.sv
// sram_mode_sequencer
//   Top-level mode sequencer that decides which requester owns the SRAM
//   controller port: VGA while IDLE, the UART receiver while UART_RX, and the
//   milestone-1 engine while M1. It also produces the one-cycle start/initialise
//   pulses for those requesters.
//
// Ports
//   Clock                 50 MHz system clock, rising-edge
//   Resetn                asynchronous active-low reset
//   UART_RX_I             raw UART line (low in IDLE = start bit -> UART_RX)
//   M1_rerun              one-cycle request to rerun milestone 1 from IDLE
//   UART_SRAM_*           UART requester SRAM port (address/write data/we_n)
//   M1_SRAM_*             milestone-1 requester SRAM port
//   VGA_SRAM_address      VGA read address (used in IDLE)
//   m1_done               milestone-1 completion level
//   SRAM_*                muxed SRAM controller port
//   UART_rx_initialize    high for the first UART_RX cycle
//   UART_rx_enable        high for the second UART_RX cycle
//   m1_start              high for the first M1 cycle
//   VGA_enable            high while IDLE
//   mode                  current state: 00 IDLE, 01 UART_RX, 10 M1
module sram_mode_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        UART_RX_I,
  input  logic        M1_rerun,
  input  logic [17:0] UART_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic        UART_SRAM_we_n,
  input  logic [17:0] M1_SRAM_address,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic        M1_SRAM_we_n,
  input  logic [17:0] VGA_SRAM_address,
  input  logic        m1_done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        UART_rx_initialize,
  output logic        UART_rx_enable,
  output logic        m1_start,
  output logic        VGA_enable,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_UART_RX = 2'b01,
    S_M1      = 2'b10
  } state_t;

  // Last timer value before the idle timeout fires.
  localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic        uart_rx_init_q, uart_rx_init_d;
  logic        uart_rx_en_q, uart_rx_en_d;
  logic        m1_start_q, m1_start_d;
  logic        vga_enable_q, vga_enable_d;

  // State register (plus every registered output).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      uart_rx_init_q <= 1'b0;
      uart_rx_en_q   <= 1'b0;
      m1_start_q     <= 1'b0;
      vga_enable_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      uart_rx_init_q <= uart_rx_init_d;
      uart_rx_en_q   <= uart_rx_en_d;
      m1_start_q     <= m1_start_d;
      vga_enable_q   <= vga_enable_d;
    end
  end

  // Next-state and idle timer.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      S_IDLE: begin
        // A start bit wins over a simultaneous rerun request.
        if (!UART_RX_I) begin
          state_d = S_UART_RX;
        end else if (M1_rerun) begin
          state_d = S_M1;
        end
      end
      S_UART_RX: begin
        // Any write restarts the idle window, even on the timeout cycle.
        if (!UART_SRAM_we_n) begin
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = S_M1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 26'd1;
        end
      end
      S_M1: begin
        // m1_done may still be high from a previous run during the start
        // cycle, so it only counts once m1_start has dropped.
        if (!m1_start_q && m1_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered control outputs, derived from the upcoming transition so each
  // pulse lines up with the state register.
  always_comb begin
    uart_rx_init_d = (state_d == S_UART_RX) && (state_q != S_UART_RX);
    uart_rx_en_d   = uart_rx_init_q && (state_d == S_UART_RX);
    m1_start_d     = (state_d == S_M1) && (state_q != S_M1);
    vga_enable_d   = (state_d == S_IDLE);
  end

  // SRAM port mux: selected purely by the registered state.
  always_comb begin
    SRAM_address    = VGA_SRAM_address;
    SRAM_write_data = 16'h0000;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_UART_RX: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_M1: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      default: begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = 16'h0000;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

  assign mode               = state_q;
  assign UART_rx_initialize = uart_rx_init_q;
  assign UART_rx_enable     = uart_rx_en_q;
  assign m1_start           = m1_start_q;
  assign VGA_enable         = vga_enable_q;

endmodule

// File: tb/tb_sram_mode_sequencer.sv
// Directed testbench for sram_mode_sequencer with TIMEOUT_CYCLES = 16.
module tb_sram_mode_sequencer;

  logic        Clock;
  logic        Resetn;
  logic        UART_RX_I;
  logic        M1_rerun;
  logic [17:0] UART_SRAM_address;
  logic [15:0] UART_SRAM_write_data;
  logic        UART_SRAM_we_n;
  logic [17:0] M1_SRAM_address;
  logic [15:0] M1_SRAM_write_data;
  logic        M1_SRAM_we_n;
  logic [17:0] VGA_SRAM_address;
  logic        m1_done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        UART_rx_initialize;
  logic        UART_rx_enable;
  logic        m1_start;
  logic        VGA_enable;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  sram_mode_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .Clock                (Clock),
    .Resetn               (Resetn),
    .UART_RX_I            (UART_RX_I),
    .M1_rerun             (M1_rerun),
    .UART_SRAM_address    (UART_SRAM_address),
    .UART_SRAM_write_data (UART_SRAM_write_data),
    .UART_SRAM_we_n       (UART_SRAM_we_n),
    .M1_SRAM_address      (M1_SRAM_address),
    .M1_SRAM_write_data   (M1_SRAM_write_data),
    .M1_SRAM_we_n         (M1_SRAM_we_n),
    .VGA_SRAM_address     (VGA_SRAM_address),
    .m1_done              (m1_done),
    .SRAM_address         (SRAM_address),
    .SRAM_write_data      (SRAM_write_data),
    .SRAM_we_n            (SRAM_we_n),
    .UART_rx_initialize   (UART_rx_initialize),
    .UART_rx_enable       (UART_rx_enable),
    .m1_start             (m1_start),
    .VGA_enable           (VGA_enable),
    .mode                 (mode)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Checks the control outputs as a group.
  task automatic chk_ctrl(input string tag, input logic [1:0] m, input logic ini,
                          input logic en, input logic st, input logic vga);
    chk({tag, ".mode"}, 32'(mode), 32'(m));
    chk({tag, ".init"}, 32'(UART_rx_initialize), 32'(ini));
    chk({tag, ".en"}, 32'(UART_rx_enable), 32'(en));
    chk({tag, ".m1_start"}, 32'(m1_start), 32'(st));
    chk({tag, ".vga"}, 32'(VGA_enable), 32'(vga));
  endtask

  initial begin
    Resetn               = 1'b1;
    UART_RX_I            = 1'b1;
    M1_rerun             = 1'b0;
    UART_SRAM_address    = 18'h0AAAA;
    UART_SRAM_write_data = 16'hAAAA;
    UART_SRAM_we_n       = 1'b1;
    M1_SRAM_address      = 18'h15555;
    M1_SRAM_write_data   = 16'h5555;
    M1_SRAM_we_n         = 1'b1;
    VGA_SRAM_address     = 18'h12345;
    m1_done              = 1'b0;

    // Asynchronous reset between clock edges.
    #2 Resetn = 1'b0;
    #1;
    chk_ctrl("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.addr", 32'(SRAM_address), 32'h12345);
    chk("reset.we_n", 32'(SRAM_we_n), 32'd1);
    chk("reset.wdata", 32'(SRAM_write_data), 32'd0);
    step();
    step();
    @(negedge Clock);
    Resetn = 1'b1;

    // Idle: VGA owns the port, other requesters are ignored.
    step();
    chk_ctrl("idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    VGA_SRAM_address = 18'h3FFFE;
    UART_SRAM_we_n   = 1'b0;
    M1_SRAM_we_n     = 1'b0;
    #1;
    chk("idle.addr_track", 32'(SRAM_address), 32'h3FFFE);
    chk("idle.we_n", 32'(SRAM_we_n), 32'd1);
    chk("idle.wdata", 32'(SRAM_write_data), 32'd0);
    UART_SRAM_we_n = 1'b1;
    M1_SRAM_we_n   = 1'b1;
    step();
    chk_ctrl("idle2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start bit for one cycle.
    UART_RX_I = 1'b0;
    step();
    UART_RX_I = 1'b1;
    chk_ctrl("rx.c1", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rx.addr", 32'(SRAM_address), 32'h0AAAA);
    chk("rx.wdata", 32'(SRAM_write_data), 32'hAAAA);
    step();
    chk_ctrl("rx.c2", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_ctrl("rx.c3", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Five write pulses, ten cycles apart.
    for (int p = 0; p < 5; p++) begin
      repeat (9) step();
      chk("rx.pulse_mode", 32'(mode), 32'd1);
      UART_SRAM_we_n = 1'b0;
      #1;
      chk("rx.we_pass", 32'(SRAM_we_n), 32'd0);
      step();
      UART_SRAM_we_n = 1'b1;
    end
    // Timeout exactly 16 cycles after the last pulse.
    repeat (15) step();
    chk("rx.before_timeout", 32'(mode), 32'd1);
    step();
    chk_ctrl("m1.c1", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("m1.addr", 32'(SRAM_address), 32'h15555);
    chk("m1.wdata", 32'(SRAM_write_data), 32'h5555);

    // m1_done during the start cycle is ignored.
    m1_done = 1'b1;
    step();
    m1_done = 1'b0;
    chk_ctrl("m1.c2", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("m1.hold", 32'(mode), 32'd2);
    m1_done = 1'b1;
    step();
    m1_done = 1'b0;
    chk_ctrl("m1.done", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("m1.done_addr", 32'(SRAM_address), 32'h3FFFE);

    // Simultaneous start bit and rerun: UART wins.
    UART_RX_I = 1'b0;
    M1_rerun  = 1'b1;
    step();
    UART_RX_I = 1'b1;
    M1_rerun  = 1'b0;
    chk_ctrl("prio", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    // Timer now 1; run to 15.
    repeat (14) step();
    chk("wt.at15", 32'(mode), 32'd1);
    UART_SRAM_we_n = 1'b0;
    step();
    UART_SRAM_we_n = 1'b1;
    chk("wt.stay", 32'(mode), 32'd1);
    repeat (15) step();
    chk("wt.before_timeout", 32'(mode), 32'd1);
    step();
    chk_ctrl("wt.m1", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-M1 while M1 is writing.
    step();
    M1_SRAM_we_n = 1'b0;
    #1;
    chk("rst.we_pass", 32'(SRAM_we_n), 32'd0);
    Resetn = 1'b0;
    #1;
    chk("rst.we_n", 32'(SRAM_we_n), 32'd1);
    chk_ctrl("rst.async", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    Resetn = 1'b1;
    M1_SRAM_we_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctrl("rst.after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Rerun path from IDLE.
    M1_rerun = 1'b1;
    step();
    M1_rerun = 1'b0;
    chk_ctrl("rerun", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    m1_done = 1'b1;
    step();
    chk("rerun.ignore", 32'(mode), 32'd2);
    step();
    m1_done = 1'b0;
    chk_ctrl("rerun.done", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
